clock_display_scan: RTL and testbench

Downstream display stage for the alarm clock core. It consumes the core's binary `hours`/`minutes`/`alarm` outputs and drives a time-multiplexed 4-digit common-cathode (or, by parameter, common-anode) 7-segment display. The display shows HH:MM, blanks the leading hours zero, shows dashes for out-of-range fields, and flashes the whole display while the alarm is asserted. It sits between `tt_um_ClockAlarm` and the pad-level wrapper outputs.

---
 rtl/clock_display_pkg.sv | 24 ++
 rtl/seg7_encode.sv | 29 ++
 rtl/clock_display_scan.sv | 171 +++++++++++++++++
 tb/tb_clock_display_scan.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/clock_display_pkg.sv
// rtl/clock_display_pkg.sv - shared constants and types for the clock display scanner
// Purpose: segment patterns (bit0=a .. bit6=g), digit index type, field limits.
package clock_display_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  // 0 = minutes ones, 1 = minutes tens, 2 = hours ones, 3 = hours tens
  typedef logic [1:0] digit_idx_t;

  localparam logic [4:0] HOURS_MAX   = 5'd23;
  localparam logic [5:0] MINUTES_MAX = 6'd59;

endpackage

// File: rtl/seg7_encode.sv
// rtl/seg7_encode.sv - combinational decimal digit to 7-segment pattern
// Purpose: map a value 0-9 to its active-high segment pattern.
// Ports:
//   i_value  in  4  decimal digit (10-15 give a blank pattern)
//   o_seg    out 7  segments, bit0=a .. bit6=g
module seg7_encode
  import clock_display_pkg::*;
(
  input  logic [3:0] i_value,
  output logic [6:0] o_seg
);

  always_comb begin
    case (i_value)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/clock_display_scan.sv
// rtl/clock_display_scan.sv - multiplexed 4-digit HH:MM 7-segment display driver
// Purpose: scan hours/minutes onto a 4-digit display with colon, leading-zero
//   blank, dashes for out-of-range fields and alarm blinking.
// Ports:
//   i_clk          in  1  clock
//   i_rst          in  1  synchronous active-high reset
//   i_hours        in  5  binary hours (valid 0-23)
//   i_minutes      in  6  binary minutes (valid 0-59)
//   i_alarm        in  1  alarm active
//   i_en           in  1  display enable
//   o_seg          out 7  segments, bit0=a .. bit6=g
//   o_dp           out 1  decimal point, lit as the colon on digit 2
//   o_digit_sel    out 4  one-hot digit strobe (bit0 = minutes ones)
//   o_frame_tick   out 1  one-cycle pulse after each frame start
module clock_display_scan
  import clock_display_pkg::*;
#(
  parameter int SCAN_DIV     = 1024,
  parameter int BLINK_FRAMES = 64,
  parameter int COMMON_ANODE = 0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [4:0] i_hours,
  input  logic [5:0] i_minutes,
  input  logic       i_alarm,
  input  logic       i_en,
  output logic [6:0] o_seg,
  output logic       o_dp,
  output logic [3:0] o_digit_sel,
  output logic       o_frame_tick
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = $clog2(2 * BLINK_FRAMES);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FC_LAST  = FW'(2 * BLINK_FRAMES - 1);
  localparam logic [FW-1:0] FC_HALF  = FW'(BLINK_FRAMES);
  localparam logic          INV      = (COMMON_ANODE != 0);

  logic [PW-1:0] r_pre;
  digit_idx_t    r_idx;
  logic          r_first;  // set by reset; marks the first edge as a frame start
  logic [4:0]    r_snap_hours;
  logic [5:0]    r_snap_minutes;
  logic          r_snap_alarm;
  logic [FW-1:0] r_fc;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic [3:0]    r_digit_sel;
  logic          r_frame_tick;

  logic       w_pre_last;
  logic       w_frame_start;
  logic       w_h_valid;
  logic       w_m_valid;
  logic [3:0] w_h_tens;
  logic [3:0] w_h_ones;
  logic [3:0] w_m_tens;
  logic [3:0] w_m_ones;
  logic [3:0] w_digit_val;
  logic [6:0] w_enc_seg;
  logic [6:0] w_seg;
  logic       w_dp;
  logic [3:0] w_sel;
  logic       w_active;

  assign w_pre_last    = (r_pre == PRE_LAST);
  assign w_frame_start = r_first | (w_pre_last & (r_idx == 2'd3));

  assign w_h_valid = (r_snap_hours <= HOURS_MAX);
  assign w_m_valid = (r_snap_minutes <= MINUTES_MAX);

  assign w_m_tens = 4'(r_snap_minutes / 6'd10);
  assign w_m_ones = 4'(r_snap_minutes % 6'd10);

  always_comb begin
    w_h_tens = 4'd0;
    w_h_ones = 4'(r_snap_hours);
    if (r_snap_hours >= 5'd20) begin
      w_h_tens = 4'd2;
      w_h_ones = 4'(r_snap_hours - 5'd20);
    end else if (r_snap_hours >= 5'd10) begin
      w_h_tens = 4'd1;
      w_h_ones = 4'(r_snap_hours - 5'd10);
    end
  end

  always_comb begin
    w_digit_val = w_m_ones;
    case (r_idx)
      2'd0: w_digit_val = w_m_ones;
      2'd1: w_digit_val = w_m_tens;
      2'd2: w_digit_val = w_h_ones;
      2'd3: w_digit_val = w_h_tens;
      default: w_digit_val = w_m_ones;
    endcase
  end

  seg7_encode u_encode (
    .i_value (w_digit_val),
    .o_seg   (w_enc_seg)
  );

  // Digit content before polarity; the held-off first edge keeps the display
  // dark until the snapshot holds real data.
  always_comb begin
    w_seg    = w_enc_seg;
    w_sel    = 4'b0001 << r_idx;
    w_dp     = (r_idx == 2'd2);
    w_active = i_en & ~r_first & ~(r_snap_alarm & (r_fc >= FC_HALF));
    if (r_idx[1] ? !w_h_valid : !w_m_valid) begin
      w_seg = SEG_DASH;
    end else if ((r_idx == 2'd3) && (w_h_tens == 4'd0)) begin
      w_seg = SEG_BLANK;
    end
    if (!w_active) begin
      w_seg = SEG_BLANK;
      w_sel = 4'b0000;
      w_dp  = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pre          <= '0;
      r_idx          <= '0;
      r_first        <= 1'b1;
      r_snap_hours   <= '0;
      r_snap_minutes <= '0;
      r_snap_alarm   <= 1'b0;
      r_fc           <= '0;
      r_seg          <= {7{INV}};
      r_dp           <= INV;
      r_digit_sel    <= {4{INV}};
      r_frame_tick   <= 1'b0;
    end else begin
      r_first <= 1'b0;
      // Scan counters hold on the first edge so digit 0 gets a full SCAN_DIV.
      if (!r_first) begin
        if (w_pre_last) begin
          r_pre <= '0;
          r_idx <= r_idx + 2'd1;
        end else begin
          r_pre <= r_pre + PW'(1);
        end
      end
      if (w_frame_start) begin
        r_snap_hours   <= i_hours;
        r_snap_minutes <= i_minutes;
        r_snap_alarm   <= i_alarm;
        // A fresh alarm starts at 0 so blinking opens with the lit phase.
        if (!i_alarm || !r_snap_alarm || (r_fc == FC_LAST)) begin
          r_fc <= '0;
        end else begin
          r_fc <= r_fc + FW'(1);
        end
      end
      r_frame_tick <= w_frame_start;
      r_seg        <= w_seg ^ {7{INV}};
      r_dp         <= w_dp ^ INV;
      r_digit_sel  <= w_sel ^ {4{INV}};
    end
  end

  assign o_seg        = r_seg;
  assign o_dp         = r_dp;
  assign o_digit_sel  = r_digit_sel;
  assign o_frame_tick = r_frame_tick;

endmodule

// File: tb/tb_clock_display_scan.sv
// tb/tb_clock_display_scan.sv - scoreboard bench for clock_display_scan
module tb_clock_display_scan;

  localparam int S = 4;

  typedef struct packed {
    logic [4:0]      h;
    logic [5:0]      m;
    logic            a;
    logic            en;
    logic            mid;
    logic            act;
    logic [3:0][6:0] s;
  } vec_t;

  typedef struct packed {
    logic            act;
    logic [3:0][6:0] s;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic       alarm;
  logic       en;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b;
  logic [3:0] sel_a, sel_b;
  logic       tick_a, tick_b;

  int   n_vec;
  int   n_err;
  bit   mon_done;
  vec_t vecs[$];
  exp_t sb_q[$];

  clock_display_scan #(.SCAN_DIV(S), .BLINK_FRAMES(2), .COMMON_ANODE(0)) u_dut_cc (
    .i_clk(clk), .i_rst(rst), .i_hours(hours), .i_minutes(minutes),
    .i_alarm(alarm), .i_en(en), .o_seg(seg_a), .o_dp(dp_a),
    .o_digit_sel(sel_a), .o_frame_tick(tick_a)
  );

  clock_display_scan #(.SCAN_DIV(S), .BLINK_FRAMES(2), .COMMON_ANODE(1)) u_dut_ca (
    .i_clk(clk), .i_rst(rst), .i_hours(hours), .i_minutes(minutes),
    .i_alarm(alarm), .i_en(en), .o_seg(seg_b), .o_dp(dp_b),
    .o_digit_sel(sel_b), .o_frame_tick(tick_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input int h, input int m, input bit a, input bit e, input bit mid,
                     input bit act, input logic [6:0] s3, input logic [6:0] s2,
                     input logic [6:0] s1, input logic [6:0] s0);
    vec_t v;
    v.h = 5'(h); v.m = 6'(m); v.a = a; v.en = e; v.mid = mid; v.act = act;
    v.s = {s3, s2, s1, s0};
    vecs.push_back(v);
  endtask

  task automatic summary_and_finish();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  endtask

  // Compares both polarities against one active-high expectation {sel, seg, dp}.
  task automatic check_out(input string name, input logic [11:0] exp_cc, input logic exp_tick);
    logic [11:0] got_cc, got_ca;
    got_cc = {sel_a, seg_a, dp_a};
    got_ca = {sel_b, seg_b, dp_b};
    n_vec += 3;
    if (got_cc !== exp_cc) begin
      n_err++;
      $display("FAIL %s cc: got %h want %h", name, got_cc, exp_cc);
    end
    if (got_ca !== ~exp_cc) begin
      n_err++;
      $display("FAIL %s ca: got %h want %h", name, got_ca, ~exp_cc);
    end
    if ({tick_a, tick_b} !== {exp_tick, exp_tick}) begin
      n_err++;
      $display("FAIL %s tick: got %b%b want %b", name, tick_a, tick_b, exp_tick);
    end
  endtask

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 8 * S && !ok; k++) begin
      @(negedge clk);
      if (tick_a) ok = 1'b1;
    end
  endtask

  // Stimulus: h/m/a of a vector are applied one frame ahead (captured at the
  // next frame start); en is applied on its own frame's tick since it is live.
  initial begin : stimulus
    bit ok;
    n_vec = 0; n_err = 0; mon_done = 1'b0;
    add(12, 34, 0, 1, 0, 1, 7'h06, 7'h5B, 7'h4F, 7'h66);
    add(12, 34, 0, 1, 0, 1, 7'h06, 7'h5B, 7'h4F, 7'h66);
    add( 9,  5, 0, 1, 0, 1, 7'h00, 7'h6F, 7'h3F, 7'h6D);
    add(25, 60, 0, 1, 0, 1, 7'h40, 7'h40, 7'h40, 7'h40);
    add(23, 59, 0, 1, 0, 1, 7'h5B, 7'h4F, 7'h6D, 7'h6F);
    add(12, 34, 0, 1, 0, 1, 7'h06, 7'h5B, 7'h4F, 7'h66);
    add(12, 35, 0, 1, 1, 1, 7'h06, 7'h5B, 7'h4F, 7'h6D);
    add(12, 35, 1, 1, 0, 1, 7'h06, 7'h5B, 7'h4F, 7'h6D);
    add(12, 35, 1, 1, 0, 1, 7'h06, 7'h5B, 7'h4F, 7'h6D);
    add(12, 35, 1, 1, 0, 0, 7'h00, 7'h00, 7'h00, 7'h00);
    add(12, 35, 1, 1, 0, 0, 7'h00, 7'h00, 7'h00, 7'h00);
    add(12, 35, 0, 1, 1, 1, 7'h06, 7'h5B, 7'h4F, 7'h6D);
    add(12, 35, 1, 1, 0, 1, 7'h06, 7'h5B, 7'h4F, 7'h6D);
    add(12, 35, 1, 1, 0, 1, 7'h06, 7'h5B, 7'h4F, 7'h6D);
    add(12, 35, 1, 1, 0, 0, 7'h00, 7'h00, 7'h00, 7'h00);
    add(12, 35, 0, 1, 0, 1, 7'h06, 7'h5B, 7'h4F, 7'h6D);
    add(12, 34, 0, 0, 0, 0, 7'h00, 7'h00, 7'h00, 7'h00);
    add(12, 34, 0, 0, 0, 0, 7'h00, 7'h00, 7'h00, 7'h00);
    add( 0,  0, 0, 1, 0, 1, 7'h00, 7'h3F, 7'h3F, 7'h3F);
    add(10,  7, 0, 1, 0, 1, 7'h06, 7'h3F, 7'h3F, 7'h07);
    add(24,  0, 0, 1, 0, 1, 7'h40, 7'h40, 7'h3F, 7'h3F);
    add(31, 63, 0, 1, 0, 1, 7'h40, 7'h40, 7'h40, 7'h40);

    rst = 1'b1;
    hours = vecs[0].h; minutes = vecs[0].m; alarm = vecs[0].a; en = vecs[0].en;
    repeat (3) @(negedge clk);
    check_out("reset_state", 12'h000, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      wait_tick(ok);
      if (!ok) begin
        n_vec++; n_err++;
        $display("FAIL frame_tick_timeout frame %0d: got no tick want tick within %0d cycles", i, 8 * S);
        summary_and_finish();
      end
      en = vecs[i].en;
      sb_q.push_back('{act: vecs[i].act, s: vecs[i].s});
      if (i + 1 < vecs.size()) begin
        if (vecs[i + 1].mid) repeat (2 * S + 1) @(negedge clk);
        hours = vecs[i + 1].h; minutes = vecs[i + 1].m; alarm = vecs[i + 1].a;
      end
    end

    for (int k = 0; k < 16 * S && !mon_done; k++) @(negedge clk);
    if (!mon_done) begin
      n_vec++; n_err++;
      $display("FAIL monitor_timeout: got running want done");
    end

    // Reset in the middle of a frame, while digit 2 is lit.
    for (int k = 0; k < 8 * S && sel_a != 4'b0100; k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_out("reset_mid_frame", 12'h000, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check_out("post_reset_edge1", 12'h000, 1'b1);
    @(negedge clk);
    check_out("post_reset_edge2", {4'b0001, 7'h40, 1'b0}, 1'b0);
    summary_and_finish();
  end

  // Monitor: after each frame tick, collects 4*S cycles and checks them
  // against the popped expectation, including the next tick on the last cycle.
  initial begin : monitor
    bit got_first;
    got_first = 1'b0;
    for (int k = 0; k < 64 && !got_first; k++) begin
      @(negedge clk);
      if (!rst && tick_a) got_first = 1'b1;
    end
    if (!got_first) begin
      n_vec++; n_err++;
      $display("FAIL first_tick: got none want tick within 64 cycles");
    end else begin
      for (int f = 0; f < vecs.size(); f++) begin
        exp_t        e;
        logic [3:0]  bad_a, bad_b;
        logic        tick_bad;
        bad_a = 4'b0; bad_b = 4'b0; tick_bad = 1'b0; e = '0;
        for (int j = 0; j < 4 * S; j++) begin
          int          d;
          logic [3:0]  sel;
          logic [11:0] exp_cc, got_cc, got_ca;
          logic        exp_tick;
          @(negedge clk);
          if (j == 0) begin
            if (sb_q.size() == 0) begin
              n_vec++; n_err++;
              $display("FAIL scoreboard_empty frame %0d: got empty want entry", f);
            end else begin
              e = sb_q.pop_front();
            end
          end
          d = j / S;
          sel = 4'b0001 << d;
          exp_cc = e.act ? {sel, e.s[d], (d == 2)} : 12'h000;
          got_cc = {sel_a, seg_a, dp_a};
          got_ca = {sel_b, seg_b, dp_b};
          exp_tick = (j == 4 * S - 1);
          if (got_cc !== exp_cc && !bad_a[d]) begin
            bad_a[d] = 1'b1;
            $display("FAIL frame%0d_digit%0d_cc cycle %0d: got %h want %h", f, d, j, got_cc, exp_cc);
          end
          if (got_ca !== ~exp_cc && !bad_b[d]) begin
            bad_b[d] = 1'b1;
            $display("FAIL frame%0d_digit%0d_ca cycle %0d: got %h want %h", f, d, j, got_ca, ~exp_cc);
          end
          if ({tick_a, tick_b} !== {exp_tick, exp_tick} && !tick_bad) begin
            tick_bad = 1'b1;
            $display("FAIL frame%0d_tick cycle %0d: got %b%b want %b", f, j, tick_a, tick_b, exp_tick);
          end
          if (j % S == S - 1) begin
            n_vec += 2;
            if (bad_a[d]) n_err++;
            if (bad_b[d]) n_err++;
          end
        end
        n_vec++;
        if (tick_bad) n_err++;
      end
    end
    mon_done = 1'b1;
  end

  initial begin : watchdog
    #200000;
    n_vec++; n_err++;
    $display("FAIL watchdog: got still running want finished");
    summary_and_finish();
  end

endmodule
